param_sync_fifo: RTL and testbench
==================================

PARAM_SYNC_FIFO -- requirements
Module: param_sync_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning data word width in bits (>=1).
REQ-002 The block SHALL have parameter ADDR_W, default 4, meaning pointer width, with DEPTH = 2**ADDR_W words.
REQ-003 The block SHALL have parameter AF_THRESH, default 14, meaning the almost_full assert level (1..DEPTH).
REQ-004 The block SHALL have parameter AE_THRESH, default 2, meaning the almost_empty assert level (0..DEPTH-1).
REQ-005 The block SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-007 The block SHALL have port wr_en, input, 1 bit: write request.
REQ-008 The block SHALL have port din, input, DATA_W bits: write data.
REQ-009 The block SHALL have port rd_en, input, 1 bit: read request.
REQ-010 The block SHALL have port clr_err, input, 1 bit: clears the sticky error flags.
REQ-011 The block SHALL have port dout, output, DATA_W bits: read data, registered.
REQ-012 The block SHALL have port dout_valid, output, 1 bit: dout was updated by a read on the previous edge.
REQ-013 The block SHALL have ports full, empty, almost_full and almost_empty, each output, 1 bit: status flags.
REQ-014 The block SHALL have port count, output, ADDR_W+1 bits: number of stored words (0..DEPTH).
REQ-015 The block SHALL have ports overflow and underflow, each output, 1 bit: sticky error flags.

Function
REQ-016 A write SHALL be accepted iff wr_en && !full, and a read SHALL be accepted iff rd_en && !empty, with both evaluated on flag values before the edge.
REQ-017 An accepted write SHALL store din at wr_ptr and increment wr_ptr modulo DEPTH; a rejected write SHALL change no state except overflow.
REQ-018 An accepted read SHALL load dout with mem[rd_ptr] and increment rd_ptr modulo DEPTH, giving 1-cycle latency; dout SHALL hold its value otherwise.
REQ-019 dout_valid SHALL be 1 for exactly the cycle after each accepted read, and 0 otherwise.
REQ-020 count SHALL be +1 on write-only, -1 on read-only, and unchanged on both or neither.
REQ-021 Simultaneous accepted read and write at any 0<count<DEPTH SHALL keep count, and the read SHALL return the oldest word.
REQ-022 When full, simultaneous wr_en and rd_en SHALL perform the read only, with count decreasing by 1 and overflow set; when empty, they SHALL perform the write only, with count increasing by 1 and underflow set.
REQ-023 The flags SHALL be derived from count: full=(count==DEPTH), empty=(count==0), almost_full=(count>=AF_THRESH), almost_empty=(count<=AE_THRESH).
REQ-024 Pointer wrap-around SHALL be seamless, preserving data order across the DEPTH-1 -> 0 transition.
REQ-025 overflow SHALL set on wr_en&&full and underflow SHALL set on rd_en&&empty; clr_err SHALL clear both on the next edge, and a set condition SHALL win over clr_err in the same cycle.
REQ-026 Memory contents SHALL NOT be reset, and no output SHALL depend on unwritten memory.

Reset
REQ-027 While rst=1: wr_ptr=0, rd_ptr=0, count=0, dout=0, dout_valid=0, overflow=0, underflow=0, empty=1, almost_empty=1, full=0, almost_full=0.
REQ-028 Reset asserted mid-operation SHALL discard all stored words immediately (asynchronously), and the first post-reset read SHALL return the first post-reset write.

Configuration
REQ-029 With macro PARAM_SYNC_FIFO_ERR_EN defined, overflow, underflow and clr_err SHALL behave per REQ-025.
REQ-030 Without PARAM_SYNC_FIFO_ERR_EN, overflow and underflow SHALL be constant 0, clr_err SHALL be ignored, and all other behaviour SHALL be unchanged.

Verification (defaults, ERR_EN defined)
REQ-031 Writing 16 words 0x00..0x0F, then reading 16 -> dout 0x00..0x0F in order, each 1 cycle after rd_en with dout_valid=1; count reaches 16 with full=1, then returns to 0 with empty=1.
REQ-032 At count=13, one write -> count=14 and almost_full=1; at count=3, one read -> count=2 and almost_empty=1.
REQ-033 At full (count=16), wr_en+rd_en with din=0xAA -> count=15, overflow=1, and 0xAA is not stored.
REQ-034 At empty, rd_en+wr_en with din=0x55 -> count=1, underflow=1, dout_valid=0; the next read returns 0x55.
REQ-035 20 writes interleaved with 20 reads at count~8 -> pointers wrap, the output sequence matches the input, and count stays constant during simultaneous operations.
REQ-036 rst pulsed at count=9 -> count=0, empty=1 and dout=0 immediately; clr_err together with a new overflow in the same cycle -> overflow remains 1.

Source files
------------

// File: rtl/param_sync_fifo.sv
// Synchronous FIFO with count-derived status flags; sticky errors when PARAM_SYNC_FIFO_ERR_EN is defined.
// Latency: dout registered, one cycle after an accepted read; dout_valid marks that cycle.
// Backpressure: writes are dropped while full and reads are ignored while empty.
module param_sync_fifo #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int AF_THRESH = 14,
    parameter int AE_THRESH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    input  logic              clr_err,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_LVL = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_LVL    = (ADDR_W+1)'(AF_THRESH);
    localparam logic [ADDR_W:0] AE_LVL    = (ADDR_W+1)'(AE_THRESH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_acc;
    logic              rd_acc;

    assign full         = (count == DEPTH_LVL);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_LVL);
    assign almost_empty = (count <= AE_LVL);

    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    // Storage is deliberately unreset; only slots below count are ever read.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
                dout   <= mem[rd_ptr];
            end
            dout_valid <= rd_acc;
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef PARAM_SYNC_FIFO_ERR_EN
    // A fresh error in the same cycle as clr_err keeps the flag set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (wr_en && full)  || (overflow  && !clr_err);
            underflow <= (rd_en && empty) || (underflow && !clr_err);
        end
    end
`else
    logic unused_clr_err;
    assign unused_clr_err = clr_err;
    assign overflow       = 1'b0;
    assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_param_sync_fifo.sv
// Bench for param_sync_fifo at default parameters; a queue model tracks stored words and flags.
module tb_param_sync_fifo;

`ifdef PARAM_SYNC_FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_en, rd_en, clr_err;
    logic [7:0] din;
    logic [7:0] dout;
    logic       dout_valid, full, empty, almost_full, almost_empty;
    logic [4:0] count;
    logic       overflow, underflow;

    param_sync_fifo dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en), .clr_err(clr_err),
        .dout(dout), .dout_valid(dout_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [7:0] sb[$];
    int         m_count;
    logic [7:0] m_dout;
    logic       m_dv, m_ovf, m_unf;

    typedef struct {
        logic       w;
        logic       r;
        logic [7:0] d;
        logic       c;
        int         cnt;
        logic       ov;
        logic       un;
        logic       dv;
    } vec_t;
    vec_t tbl[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        sb.delete();
        m_count = 0;
        m_dout  = 8'h00;
        m_dv    = 1'b0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
    endtask

    // One clock with the given inputs, then compare every output with the model.
    task automatic step(input logic w, input logic r, input logic [7:0] d, input logic c);
        int  old;
        bit  wa, ra;
        wr_en = w; rd_en = r; din = d; clr_err = c;
        @(posedge clk);
        #1;
        old = m_count;
        wa  = w && (old < 16);
        ra  = r && (old > 0);
        m_dv = ra;
        if (ra) m_dout = sb.pop_front();
        if (wa) sb.push_back(d);
        m_count = sb.size();
        if (ERR_EN) begin
            m_ovf = (w && old == 16) || (m_ovf && !c);
            m_unf = (r && old == 0)  || (m_unf && !c);
        end
        wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0;
        chk("count", 32'(count), 32'(m_count));
        chk("full", 32'(full), 32'(m_count == 16));
        chk("empty", 32'(empty), 32'(m_count == 0));
        chk("almost_full", 32'(almost_full), 32'(m_count >= 14));
        chk("almost_empty", 32'(almost_empty), 32'(m_count <= 2));
        chk("dout_valid", 32'(dout_valid), 32'(m_dv));
        chk("dout", 32'(dout), 32'(m_dout));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("underflow", 32'(underflow), 32'(m_unf));
    endtask

    task automatic fill_to(input int n);
        while (m_count < n) step(1'b1, 1'b0, 8'(8'h30 + m_count), 1'b0);
        while (m_count > n) step(1'b0, 1'b1, 8'h00, 1'b0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear before any clock.
    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        model_clear();
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_dout", 32'(dout), 32'd0);
        chk("rst_dv", 32'(dout_valid), 32'd0);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        tbl[0] = '{w:1'b1, r:1'b1, d:8'h55, c:1'b0, cnt:1, ov:1'b0, un:1'b1, dv:1'b0};
        tbl[1] = '{w:1'b0, r:1'b1, d:8'h00, c:1'b0, cnt:0, ov:1'b0, un:1'b1, dv:1'b1};
        tbl[2] = '{w:1'b0, r:1'b1, d:8'h00, c:1'b1, cnt:0, ov:1'b0, un:1'b1, dv:1'b0};
        tbl[3] = '{w:1'b0, r:1'b0, d:8'h00, c:1'b1, cnt:0, ov:1'b0, un:1'b0, dv:1'b0};

        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; din = 8'h00;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        chk("init_count", 32'(count), 32'd0);
        chk("init_empty", 32'(empty), 32'd1);
        chk("init_ae", 32'(almost_empty), 32'd1);
        chk("init_af", 32'(almost_full), 32'd0);
        chk("init_dout", 32'(dout), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Empty-FIFO simultaneous read/write, then underflow clear behaviour.
        foreach (tbl[i]) begin
            step(tbl[i].w, tbl[i].r, tbl[i].d, tbl[i].c);
            chk("tbl_count", 32'(count), 32'(tbl[i].cnt));
            chk("tbl_ovf", 32'(overflow), 32'(tbl[i].ov & ERR_EN));
            chk("tbl_unf", 32'(underflow), 32'(tbl[i].un & ERR_EN));
            chk("tbl_dv", 32'(dout_valid), 32'(tbl[i].dv));
        end
        chk("tbl_dout55", 32'(dout), 32'h55);

        // Fill 0x00..0x0F, then overflow attempt with read at full.
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i), 1'b0);
        chk("fill_count", 32'(count), 32'd16);
        chk("fill_full", 32'(full), 32'd1);
        step(1'b1, 1'b1, 8'hAA, 1'b0);
        chk("ovf_count", 32'(count), 32'd15);
        chk("ovf_flag", 32'(overflow), 32'(ERR_EN));
        chk("ovf_dout0", 32'(dout), 32'h00);
        for (int i = 1; i < 16; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            chk("drain_dout", 32'(dout), 32'(i));
        end
        chk("drain_empty", 32'(empty), 32'd1);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Almost-full / almost-empty thresholds.
        fill_to(13);
        chk("af_at13", 32'(almost_full), 32'd0);
        step(1'b1, 1'b0, 8'hC1, 1'b0);
        chk("af_at14", 32'(almost_full), 32'd1);
        fill_to(3);
        chk("ae_at3", 32'(almost_empty), 32'd0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("ae_at2", 32'(almost_empty), 32'd1);

        // Steady-state streaming across the pointer wrap.
        fill_to(8);
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 1'b1, 8'(8'h80 + i), 1'b0);
            chk("stream_count", 32'(count), 32'd8);
        end
        fill_to(9);
        async_reset();

        // First post-reset write must be the first post-reset read.
        step(1'b1, 1'b0, 8'h5A, 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        chk("post_rst_dout", 32'(dout), 32'h5A);

        // clr_err in the same cycle as a fresh overflow keeps it set.
        fill_to(16);
        step(1'b1, 1'b0, 8'hEE, 1'b1);
        chk("ovf_vs_clr", 32'(overflow), 32'(ERR_EN));
        step(1'b0, 1'b0, 8'h00, 1'b1);
        chk("ovf_cleared", 32'(overflow), 32'd0);
        fill_to(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
